adsr_envelope: RTL and testbench

- Per-voice ADSR amplitude envelope plus VCA, sitting directly downstream of the NCO and upstream of the I2S transmitter.
- Each 48 kHz tick it captures the NCO sample, advances a 16-bit envelope level through attack/decay/sustain/release, and outputs the sample scaled by that level.
- env_active tells tone_frequency_calculator to keep the NCO unmuted until the release tail has finished.

---
 rtl/synth_pkg.sv | 16 +
 rtl/env_vca.sv | 46 ++++
 rtl/adsr_envelope.sv | 162 ++++++++++++++++
 tb/tb_adsr_envelope.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared synth-voice definitions: envelope state encoding and common widths.
// Also used by the nco and i2s_transmitter blocks.
package synth_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [15:0] ENV_FULL = 16'hFFFF;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/env_vca.sv
// Registered VCA: multiplies the captured signed sample by the unsigned
// envelope level (zero-extended to a signed operand), then keeps the upper
// half. Two register stages: product, then output. Kept separate so the
// multiply can be swapped for a Booth implementation without touching the
// envelope logic.
module env_vca
  import synth_pkg::*;
#(
  parameter int SMP_W = SAMPLE_W,
  parameter int LVL_W = 16
) (
  input  logic                    master_clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic signed [SMP_W-1:0] sample,
  input  logic [LVL_W-1:0]        level,
  output logic signed [SMP_W-1:0] sample_out
);

  logic signed [SMP_W+LVL_W:0] prod_q;
  logic                        prod_valid;
  // The top bit only carries sign extension; the level operand is never
  // negative so the product always fits below it.
  logic                        unused_prod_msb;

  assign unused_prod_msb = prod_q[SMP_W+LVL_W];

  // Stage 1 registers the product, stage 2 the shifted result, each only
  // when the stage before it holds a fresh value.
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      prod_q     <= '0;
      prod_valid <= 1'b0;
      sample_out <= '0;
    end else begin
      prod_valid <= valid;
      if (valid) begin
        prod_q <= sample * $signed({1'b0, level});
      end
      if (prod_valid) begin
        sample_out <= prod_q[LVL_W +: SMP_W];
      end
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope and VCA. Each sample tick captures the NCO sample
// and the gate, advances the envelope one step on the next cycle, and the
// VCA produces the scaled sample two cycles after that.
//
// Tick handshake: sample_clk_en is a one-cycle strobe with no back-pressure;
// every strobe seen while out of reset is accepted, and each pipeline stage
// carries a valid flag that is high for exactly one cycle per accepted tick.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int LVL_W = 16,
  parameter int SMP_W = SAMPLE_W
) (
  input  logic                    master_clk,
  input  logic                    rst,
  input  logic                    sample_clk_en,
  input  logic                    gate,
  input  logic signed [SMP_W-1:0] sample_in,
  input  logic [LVL_W-1:0]        attack_step,
  input  logic [LVL_W-1:0]        decay_step,
  input  logic [LVL_W-1:0]        sustain_level,
  input  logic [LVL_W-1:0]        release_step,
  output logic signed [SMP_W-1:0] sample_out,
  output logic [LVL_W-1:0]        env_level,
  output logic [2:0]              env_state,
  output logic                    env_active
);

  localparam logic [LVL_W:0] FULL_EXT = {1'b0, {LVL_W{1'b1}}};

  logic                    rst_seen;
  logic                    tick_ok;
  logic                    cap_valid;
  logic                    upd_valid;
  logic                    gate_cap;
  logic                    gate_prev;
  logic                    active_q;
  logic signed [SMP_W-1:0] smp_cap;
  env_state_t              state_q;
  env_state_t              att_state;
  logic [LVL_W-1:0]        level_q;
  logic [LVL_W-1:0]        att_level;
  logic [LVL_W:0]          att_sum;
  logic [LVL_W:0]          dec_thr;
  logic                    att_done;
  logic                    dec_done;
  logic                    rel_done;
  logic                    rise;

  // A strobe in the very cycle rst is released is dropped: rst_seen only
  // goes high on the first clock edge after release.
  assign tick_ok = sample_clk_en & rst_seen;

  // Saturating comparisons are done one bit wider so sums cannot wrap.
  assign att_sum   = {1'b0, level_q} + {1'b0, attack_step};
  assign att_done  = att_sum >= FULL_EXT;
  assign att_level = att_done ? {LVL_W{1'b1}} : att_sum[LVL_W-1:0];
  assign att_state = att_done ? ENV_DECAY : ENV_ATTACK;
  assign dec_thr   = {1'b0, sustain_level} + {1'b0, decay_step};
  assign dec_done  = {1'b0, level_q} <= dec_thr;
  assign rel_done  = level_q <= release_step;
  assign rise      = gate_cap & ~gate_prev;

  // Tick capture stage: latch sample and gate at the strobe.
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      rst_seen  <= 1'b0;
      cap_valid <= 1'b0;
      smp_cap   <= '0;
      gate_cap  <= 1'b0;
    end else begin
      rst_seen  <= 1'b1;
      cap_valid <= tick_ok;
      if (tick_ok) begin
        smp_cap  <= sample_in;
        gate_cap <= gate;
      end
    end
  end

  // Envelope FSM: one state/level update per captured tick. A retrigger
  // keeps the current level; only from IDLE (which has no step of its own)
  // is the first attack step taken on the trigger tick.
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ENV_IDLE;
      level_q   <= '0;
      active_q  <= 1'b0;
      gate_prev <= 1'b0;
      upd_valid <= 1'b0;
    end else begin
      upd_valid <= cap_valid;
      if (cap_valid) begin
        gate_prev <= gate_cap;
        if (rise) begin
          active_q <= 1'b1;
          if (state_q == ENV_IDLE) begin
            state_q <= att_state;
            level_q <= att_level;
          end else begin
            state_q <= ENV_ATTACK;
          end
        end else begin
          case (state_q)
            ENV_IDLE: begin
              level_q  <= '0;
              active_q <= 1'b0;
            end
            ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN: begin
              if (!gate_cap) begin
                state_q <= ENV_RELEASE;
              end else if (state_q == ENV_ATTACK) begin
                state_q <= att_state;
                level_q <= att_level;
              end else if (state_q == ENV_DECAY) begin
                if (dec_done) begin
                  state_q <= ENV_SUSTAIN;
                  level_q <= sustain_level;
                end else begin
                  level_q <= level_q - decay_step;
                end
              end else begin
                level_q <= sustain_level;
              end
            end
            ENV_RELEASE: begin
              if (rel_done) begin
                state_q  <= ENV_IDLE;
                level_q  <= '0;
                active_q <= 1'b0;
              end else begin
                level_q <= level_q - release_step;
              end
            end
            default: begin
              state_q  <= ENV_IDLE;
              level_q  <= '0;
              active_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign env_level  = level_q;
  assign env_state  = state_q;
  assign env_active = active_q;

  env_vca #(
    .SMP_W(SMP_W),
    .LVL_W(LVL_W)
  ) u_vca (
    .master_clk(master_clk),
    .rst       (rst),
    .valid     (upd_valid),
    .sample    (smp_cap),
    .level     (level_q),
    .sample_out(sample_out)
  );

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope. The driver pushes hand-computed
// expectations per tick; a monitor pops them when it sees the tick and checks
// level/state one edge later, output hold two edges later and the scaled
// sample three edges later.
module tb_adsr_envelope;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ATK  = 3'd1;
  localparam logic [2:0] S_DEC  = 3'd2;
  localparam logic [2:0] S_SUS  = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  logic        master_clk;
  logic        rst;
  logic        sample_clk_en;
  logic        gate;
  logic [15:0] sample_in;
  logic [15:0] attack_step;
  logic [15:0] decay_step;
  logic [15:0] sustain_level;
  logic [15:0] release_step;
  logic [15:0] sample_out;
  logic [15:0] env_level;
  logic [2:0]  env_state;
  logic        env_active;

  // {level[15:0], state[2:0], active, sample[15:0], prev_sample[15:0]}
  logic [51:0] exp_q[$];
  logic [15:0] last_smp;
  logic        tb_skip;
  int          checks;
  int          errors;

  adsr_envelope dut (
    .master_clk   (master_clk),
    .rst          (rst),
    .sample_clk_en(sample_clk_en),
    .gate         (gate),
    .sample_in    (sample_in),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_level(sustain_level),
    .release_step (release_step),
    .sample_out   (sample_out),
    .env_level    (env_level),
    .env_state    (env_state),
    .env_active   (env_active)
  );

  // Clock
  initial master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one tick, expectations pushed before the strobe, 8-cycle period.
  // Gate and sample are disturbed between ticks; only captured values count.
  task automatic do_tick(input logic g, input logic [15:0] smp, input logic [15:0] lvl,
                         input logic [2:0] st, input logic [15:0] o);
    @(negedge master_clk);
    gate      = g;
    sample_in = smp;
    exp_q.push_back({lvl, st, (st != S_IDLE), o, last_smp});
    last_smp  = o;
    sample_clk_en = 1'b1;
    @(negedge master_clk);
    sample_clk_en = 1'b0;
    sample_in     = 16'h1234;
    gate          = ~g;
    repeat (6) @(negedge master_clk);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [51:0] e;
    forever begin
      @(posedge master_clk);
      if (sample_clk_en && rst && !tb_skip) begin
        if (exp_q.size() == 0) begin
          check("tick_without_expectation", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          @(posedge master_clk);
          #1;
          check("env_level", {16'h0, env_level}, {16'h0, e[51:36]});
          check("env_state", {29'h0, env_state}, {29'h0, e[35:33]});
          check("env_active", {31'h0, env_active}, {31'h0, e[32]});
          @(posedge master_clk);
          #1;
          check("sample_out_hold", {16'h0, sample_out}, {16'h0, e[15:0]});
          @(posedge master_clk);
          #1;
          check("sample_out", {16'h0, sample_out}, {16'h0, e[31:16]});
        end
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    checks = 0; errors = 0; last_smp = 16'h0; tb_skip = 1'b0;
    rst = 1'b0; sample_clk_en = 1'b0; gate = 1'b0; sample_in = 16'h0;
    attack_step = 16'h4000; decay_step = 16'h1000;
    sustain_level = 16'h8000; release_step = 16'h3000;
    repeat (3) @(negedge master_clk);
    rst = 1'b1;
    @(negedge master_clk);
    check("reset_sample_out", {16'h0, sample_out}, 32'h0);
    check("reset_env_level", {16'h0, env_level}, 32'h0);
    check("reset_env_state", {29'h0, env_state}, 32'h0);
    check("reset_env_active", {31'h0, env_active}, 32'h0);

    // Attack saturation
    do_tick(1, 16'h4000, 16'h4000, S_ATK, 16'h1000);
    do_tick(1, 16'h4000, 16'h8000, S_ATK, 16'h2000);
    do_tick(1, 16'h4000, 16'hC000, S_ATK, 16'h3000);
    do_tick(1, 16'h4000, 16'hFFFF, S_DEC, 16'h3FFF);
    // Decay to sustain; last tick also covers -32768 at half scale
    do_tick(1, 16'h4000, 16'hEFFF, S_DEC, 16'h3BFF);
    do_tick(1, 16'h4000, 16'hDFFF, S_DEC, 16'h37FF);
    do_tick(1, 16'h4000, 16'hCFFF, S_DEC, 16'h33FF);
    do_tick(1, 16'h4000, 16'hBFFF, S_DEC, 16'h2FFF);
    do_tick(1, 16'h4000, 16'hAFFF, S_DEC, 16'h2BFF);
    do_tick(1, 16'h4000, 16'h9FFF, S_DEC, 16'h27FF);
    do_tick(1, 16'h4000, 16'h8FFF, S_DEC, 16'h23FF);
    do_tick(1, 16'h8000, 16'h8000, S_SUS, 16'hC000);
    // Sustain: -1 rounds toward minus infinity; live sustain tracking
    do_tick(1, 16'hFFFF, 16'h8000, S_SUS, 16'hFFFF);
    sustain_level = 16'h6000;
    do_tick(1, 16'h7FFF, 16'h6000, S_SUS, 16'h2FFF);
    sustain_level = 16'h8000;
    do_tick(1, 16'h4000, 16'h8000, S_SUS, 16'h2000);
    // Release to idle
    do_tick(0, 16'h4000, 16'h8000, S_REL, 16'h2000);
    do_tick(0, 16'h4000, 16'h5000, S_REL, 16'h1400);
    do_tick(0, 16'h4000, 16'h2000, S_REL, 16'h0800);
    do_tick(0, 16'h4000, 16'h0000, S_IDLE, 16'h0000);
    // Retrigger during release at 0x5000
    do_tick(1, 16'h4000, 16'h4000, S_ATK, 16'h1000);
    do_tick(1, 16'h4000, 16'h8000, S_ATK, 16'h2000);
    do_tick(0, 16'h4000, 16'h8000, S_REL, 16'h2000);
    do_tick(0, 16'h4000, 16'h5000, S_REL, 16'h1400);
    do_tick(1, 16'h4000, 16'h5000, S_ATK, 16'h1400);
    do_tick(1, 16'h4000, 16'h9000, S_ATK, 16'h2400);
    // Zero attack step holds the level
    attack_step = 16'h0000;
    do_tick(1, 16'h4000, 16'h9000, S_ATK, 16'h2400);
    attack_step = 16'h4000;

    // Async reset between T+1 and T+3 of an attack tick
    tb_skip = 1'b1;
    @(negedge master_clk);
    gate = 1'b1; sample_in = 16'h4000; sample_clk_en = 1'b1;
    @(negedge master_clk);
    sample_clk_en = 1'b0;
    @(negedge master_clk);
    check("mid_attack_level", {16'h0, env_level}, 32'h0000D000);
    check("pre_reset_sample_out", {16'h0, sample_out}, 32'h00002400);
    rst = 1'b0;
    #1;
    check("async_rst_sample_out", {16'h0, sample_out}, 32'h0);
    check("async_rst_env_level", {16'h0, env_level}, 32'h0);
    check("async_rst_env_state", {29'h0, env_state}, 32'h0);
    check("async_rst_env_active", {31'h0, env_active}, 32'h0);
    last_smp = 16'h0;
    @(negedge master_clk);
    sample_clk_en = 1'b1;
    @(negedge master_clk);
    sample_clk_en = 1'b0;
    @(negedge master_clk);
    rst = 1'b1; sample_clk_en = 1'b1; gate = 1'b1; sample_in = 16'h4000;
    @(negedge master_clk);
    sample_clk_en = 1'b0;
    tb_skip = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge master_clk);
      check("post_reset_idle", {env_level, 13'h0, env_state}, 32'h0);
      check("post_reset_sample_out", {16'h0, sample_out}, 32'h0);
    end
    do_tick(1, 16'h4000, 16'h4000, S_ATK, 16'h1000);
    do_tick(1, 16'h4000, 16'h8000, S_ATK, 16'h2000);

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge master_clk);
      guard++;
    end
    if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 32'd0);
    repeat (6) @(negedge master_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
